// File: rtl/mem_rd_arbiter_pkg.sv
// Shared definitions for the memory read arbiter: read-type encoding,
// AXI burst constant, requester indices and a line-alignment helper.
package mem_rd_arbiter_pkg;

  typedef enum logic [2:0] {
    RD_BYTE = 3'd0,
    RD_HALF = 3'd1,
    RD_WORD = 3'd2,
    RD_LINE = 3'd4
  } rd_type_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Requester indices used by the round-robin arbiter and its rr_last state
  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

  // Clears the byte-offset-within-line bits of an address
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int line_bytes);
    return addr & ~(32'(line_bytes) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// AXI read-channel bundle (AR + R) between the arbiter (master) and the
// AXI bridge (slave).
//
// Handshake rules: an AR transfer happens on a cycle where arvalid and
// arready are both 1; arvalid, once raised, stays 1 with a stable payload
// until that cycle. An R beat transfers on a cycle where rvalid and rready
// are both 1; the arbiter keeps rready at 1 so every beat is consumed.
interface mem_rd_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/mem_rd_arbiter_rr_arb2.sv
// Two-input round-robin grant. rr_last remembers which requester was
// accepted most recently; on a tie the other one wins.
module mem_rd_arbiter_rr_arb2
  import mem_rd_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic rr_last;

  // One-hot grant: a lone requester wins, a tie goes to the one not in rr_last
  always_comb begin
    grant = req;
    if (req[0] && req[1]) begin
      grant = (rr_last == REQ_IC) ? 2'b10 : 2'b01;
    end
  end

  // Remember the winner of every accepted request; reset favours dcache first
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= REQ_IC;
    end else if (accept) begin
      rr_last <= grant[1] ? REQ_DC : REQ_IC;
    end
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares one AXI read channel between the icache and dcache read ports.
// One AR request is registered at a time and tagged with a per-requester
// ARID; R beats are routed back by RID. Each requester may have at most one
// read outstanding. Optional wait-cycle counters are compiled in when
// MEM_RD_ARB_PERF_EN is defined.
module mem_rd_arbiter
  import mem_rd_arbiter_pkg::*;
#(
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] IC_ID      = 4'd0,
  parameter logic [3:0] DC_ID      = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ic_rd_req,
  input  logic [2:0]  ic_rd_type,
  input  logic [31:0] ic_rd_addr,
  output logic        ic_rd_rdy,
  output logic        ic_ret_valid,
  output logic        ic_ret_last,
  output logic [31:0] ic_ret_data,
  input  logic        dc_rd_req,
  input  logic [2:0]  dc_rd_type,
  input  logic [31:0] dc_rd_addr,
  output logic        dc_rd_rdy,
  output logic        dc_ret_valid,
  output logic        dc_ret_last,
  output logic [31:0] dc_ret_data,
  mem_rd_arbiter_if.master axi,
`ifdef MEM_RD_ARB_PERF_EN
  output logic [31:0] perf_ic_wait,
  output logic [31:0] perf_dc_wait,
`endif
  output logic        ar_state
);

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_SEND = 1'b1;
  localparam int LINE_BYTES = LINE_WORDS * 4;

  logic [0:0]  state;
  logic        ic_out, dc_out;
  logic [1:0]  elig, grant;
  logic        accept, ar_hs, ic_hit, dc_hit;
  logic        sel_dc, sel_line;
  logic [2:0]  sel_type;
  logic [31:0] sel_addr;
  logic [3:0]  sel_id;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        unused_rresp;

  // Only AR_IDLE accepts, which also keeps the owner of a pending AR out
  assign elig[0] = (state == AR_IDLE) && ic_rd_req && !ic_out;
  assign elig[1] = (state == AR_IDLE) && dc_rd_req && !dc_out;

  mem_rd_arbiter_rr_arb2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (elig),
    .accept (accept),
    .grant  (grant)
  );

  assign ic_rd_rdy = grant[0];
  assign dc_rd_rdy = grant[1];
  assign accept    = |grant;
  assign ar_hs     = (state == AR_SEND) && axi.arready;
  assign ar_state  = state;

  // Pick the granted requester's request fields for the AR payload
  always_comb begin
    sel_dc   = grant[1];
    sel_type = sel_dc ? dc_rd_type : ic_rd_type;
    sel_addr = sel_dc ? dc_rd_addr : ic_rd_addr;
    sel_id   = sel_dc ? DC_ID : IC_ID;
    sel_line = (sel_type == 3'(RD_LINE));
  end

  // AR FSM: capture the payload on acceptance, hold it until arready
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= AR_IDLE;
      ar_id    <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
    end else begin
      case (state)
        AR_IDLE: begin
          if (accept) begin
            state    <= AR_SEND;
            ar_id    <= sel_id;
            ar_addr  <= sel_line ? line_align(sel_addr, LINE_BYTES) : sel_addr;
            ar_len   <= sel_line ? 8'(LINE_WORDS - 1) : 8'd0;
            ar_size  <= sel_line ? 3'd2 : {1'b0, sel_type[1:0]};
            ar_burst <= AXI_BURST_INCR;
          end
        end
        default: begin
          if (axi.arready) state <= AR_IDLE;
        end
      endcase
    end
  end

  assign axi.arid    = ar_id;
  assign axi.araddr  = ar_addr;
  assign axi.arlen   = ar_len;
  assign axi.arsize  = ar_size;
  assign axi.arburst = ar_burst;
  assign axi.arvalid = (state == AR_SEND);
  assign axi.rready  = 1'b1;

  // Per-beat routing by RID; beats with any other RID are dropped
  assign ic_hit       = axi.rvalid && (axi.rid == IC_ID);
  assign dc_hit       = axi.rvalid && (axi.rid == DC_ID);
  assign ic_ret_valid = ic_hit;
  assign ic_ret_last  = ic_hit && axi.rlast;
  assign ic_ret_data  = axi.rdata;
  assign dc_ret_valid = dc_hit;
  assign dc_ret_last  = dc_hit && axi.rlast;
  assign dc_ret_data  = axi.rdata;

  // Error responses are handled by the bridge, not here
  assign unused_rresp = ^axi.rresp;

  // Outstanding flags: set when the AR is handed off, cleared by the last beat
  always_ff @(posedge clk) begin
    if (reset) begin
      ic_out <= 1'b0;
      dc_out <= 1'b0;
    end else begin
      if (ic_hit && axi.rlast) ic_out <= 1'b0;
      if (dc_hit && axi.rlast) dc_out <= 1'b0;
      if (ar_hs && (ar_id == IC_ID)) ic_out <= 1'b1;
      if (ar_hs && (ar_id == DC_ID)) dc_out <= 1'b1;
    end
  end

`ifdef MEM_RD_ARB_PERF_EN
  // Saturating counts of cycles a requester is asking but not accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ic_wait <= '0;
      perf_dc_wait <= '0;
    end else begin
      if (ic_rd_req && !ic_rd_rdy && (perf_ic_wait != '1)) perf_ic_wait <= perf_ic_wait + 32'd1;
      if (dc_rd_req && !dc_rd_rdy && (perf_dc_wait != '1)) perf_dc_wait <= perf_dc_wait + 32'd1;
    end
  end
`endif

endmodule
